// File: rtl/nes_pad_reader_pkg.sv
// nes_pad_pkg: shared constants and FSM encoding for the NES pad reader.
package nes_pad_pkg;
   localparam int NES_BITS  = 8;
   localparam int BTN_A     = 0;
   localparam int BTN_B     = 1;
   localparam int BTN_SEL   = 2;
   localparam int BTN_START = 3;
   localparam int BTN_UP    = 4;
   localparam int BTN_DOWN  = 5;
   localparam int BTN_LEFT  = 6;
   localparam int BTN_RIGHT = 7;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      DONE  = 3'd4
   } state_e;
endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// sync_2ff: two-flop synchronizer, resets to all ones (idle level of pulled-up inputs).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_q, sync_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end
   assign q = sync_q;
endmodule

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: drives NES pad latch/clock and assembles the 8 buttons active-high.
// Optional NES_PAD_DEBOUNCE_EN: buttons update only when two consecutive reads agree.
module nes_pad_reader
   import nes_pad_pkg::*;
#(
   parameter  int HALF_PERIOD = 151,
   localparam int CNT_W       = $clog2(2*HALF_PERIOD)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                nes_data,
   output logic                nes_latch,
   output logic                nes_clk,
   output logic [NES_BITS-1:0] buttons,
   output logic                valid,
   output logic                busy
);
   localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(2*HALF_PERIOD-1);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_PERIOD-1);
   logic                sync_data;
   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [2:0]          idx_q;
   logic [NES_BITS-1:0] shift_q, buttons_q;
   logic                latch_q, clk_q, valid_q, busy_q;
`ifdef NES_PAD_DEBOUNCE_EN
   logic [NES_BITS-1:0] prev_q;
`endif
   sync_2ff #(.WIDTH(1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (nes_data),
      .q     (sync_data)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         buttons_q <= '0;
         latch_q   <= 1'b0;
         clk_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
         prev_q    <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q <= LATCH;
               cnt_q   <= LATCH_LOAD;
               latch_q <= 1'b1;
               busy_q  <= 1'b1;
            end
            LATCH: if (cnt_q == '0) begin
               state_q <= LOW;
               cnt_q   <= HALF_LOAD;
               idx_q   <= '0;
               latch_q <= 1'b0;
            end else cnt_q <= cnt_q - 1'b1;
            // Pad buttons are active-low on the wire; store them active-high.
            LOW: if (cnt_q == '0) begin
               state_q        <= HIGH;
               cnt_q          <= HALF_LOAD;
               shift_q[idx_q] <= ~sync_data;
               clk_q          <= 1'b1;
            end else cnt_q <= cnt_q - 1'b1;
            HIGH: if (cnt_q == '0) begin
               clk_q <= 1'b0;
               if (idx_q == 3'd7) begin
                  state_q <= DONE;
                  valid_q <= 1'b1;
`ifdef NES_PAD_DEBOUNCE_EN
                  prev_q  <= shift_q;
                  if (shift_q == prev_q) buttons_q <= shift_q;
`else
                  buttons_q <= shift_q;
`endif
               end else begin
                  state_q <= LOW;
                  cnt_q   <= HALF_LOAD;
                  idx_q   <= idx_q + 3'd1;
               end
            end else cnt_q <= cnt_q - 1'b1;
            DONE: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign nes_latch = latch_q;
   assign nes_clk   = clk_q;
   assign buttons   = buttons_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: table-driven checks of the NES pad reader against a behavioural pad model.
module tb_nes_pad_reader;
   localparam int HP = 4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       nes_data, nes_latch, nes_clk, valid, busy;
   logic [7:0] buttons;
   logic [7:0] pressed = 8'h00;
   logic [7:0] pad_sr = 8'hFF;
   bit         no_pad = 1'b0;
   int         rise_total = 0;
   int         n_vec = 0;
   int         n_fail = 0;

   typedef struct {
      logic [7:0] p;
      bit         np;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   nes_pad_reader #(.HALF_PERIOD(HP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .nes_data  (nes_data),
      .nes_latch (nes_latch),
      .nes_clk   (nes_clk),
      .buttons   (buttons),
      .valid     (valid),
      .busy      (busy)
   );

   // 4021-style pad: parallel load on latch, shift toward bit 0 on each clock rise, ones shift in.
   always @(posedge nes_latch or posedge nes_clk) begin
      if (nes_latch) pad_sr = ~pressed;
      else begin
         pad_sr = {1'b1, pad_sr[7:1]};
         rise_total = rise_total + 1;
      end
   end
   assign nes_data = no_pad ? 1'b1 : pad_sr[0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Starts a read with start high in the cycle before cycle 1, observes cycles 1..76.
   task automatic run_read(input logic [7:0] p, input bit np, input int extra_at,
                           output int vcyc, output int vcnt, output int rises,
                           output int lfirst, output int lcnt,
                           output logic busy_end, output logic [7:0] btn);
      int r0;
      pressed = p;
      no_pad = np;
      r0 = rise_total;
      vcyc = -1; vcnt = 0; lfirst = -1; lcnt = 0; busy_end = 1'b1; btn = 8'hxx;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 76; k++) begin
         start = (k == extra_at);
         if (nes_latch) begin
            lcnt++;
            if (lfirst < 0) lfirst = k;
         end
         if (valid) begin
            vcnt++;
            if (vcyc < 0) begin
               vcyc = k;
               btn = buttons;
            end
         end
         if (k == 74) busy_end = busy;
         @(negedge clk);
      end
      start = 1'b0;
      rises = rise_total - r0;
   endtask

   initial begin
      int vcyc, vcnt, rises, lfirst, lcnt, n;
      logic busy_end;
      logic [7:0] btn, exp_btn;
      tbl[0] = '{8'h01, 1'b0, 8'h01};
      tbl[1] = '{8'h90, 1'b0, 8'h90};
      tbl[2] = '{8'h00, 1'b1, 8'h00};
      tbl[3] = '{8'hFF, 1'b0, 8'hFF};
      tbl[4] = '{8'h5A, 1'b0, 8'h5A};
      tbl[5] = '{8'hA5, 1'b0, 8'hA5};

      repeat (3) @(negedge clk);
      check("reset_latch", 32'(nes_latch), 0);
      check("reset_clk", 32'(nes_clk), 0);
      check("reset_buttons", 32'(buttons), 0);
      check("reset_valid", 32'(valid), 0);
      check("reset_busy", 32'(busy), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
`ifdef NES_PAD_DEBOUNCE_EN
         run_read(tbl[i].p, tbl[i].np, 0, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
         check("prime_valid_count", 32'(vcnt), 1);
`endif
         run_read(tbl[i].p, tbl[i].np, 0, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
         check("latch_first_cycle", 32'(lfirst), 1);
         check("latch_cycles", 32'(lcnt), 8);
         check("clk_rises", 32'(rises), 8);
         check("valid_cycle", 32'(vcyc), 73);
         check("valid_count", 32'(vcnt), 1);
         check("buttons_at_valid", 32'(btn), 32'(tbl[i].exp));
         check("busy_after_done", 32'(busy_end), 0);
         check("buttons_hold", 32'(buttons), 32'(tbl[i].exp));
      end

      // Second start while busy is ignored.
      run_read(8'h90, 1'b0, 20, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
`ifdef NES_PAD_DEBOUNCE_EN
      exp_btn = 8'hA5;
`else
      exp_btn = 8'h90;
`endif
      check("busy_start_valid_count", 32'(vcnt), 1);
      check("busy_start_valid_cycle", 32'(vcyc), 73);
      check("busy_start_rises", 32'(rises), 8);
      check("busy_start_latch", 32'(lcnt), 8);
      check("busy_start_buttons", 32'(btn), 32'(exp_btn));

      // Start coincident with valid is dropped.
      run_read(8'h03, 1'b0, 73, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
      check("coinc_latch_cycles", 32'(lcnt), 8);
      check("coinc_busy_end", 32'(busy_end), 0);
      check("coinc_busy_now", 32'(busy), 0);
      check("coinc_rises", 32'(rises), 8);

      // Start in the cycle after valid is accepted.
      run_read(8'h01, 1'b0, 74, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
      check("b2b_first_valid", 32'(vcyc), 73);
      check("b2b_latch_now", 32'(nes_latch), 1);
      check("b2b_busy_now", 32'(busy), 1);
      n = -1;
      for (int k = 0; k < 200; k++) begin
         if (valid) begin
            n = k;
            break;
         end
         @(negedge clk);
      end
      check("b2b_second_valid_delay", 32'(n), 70);
      check("b2b_second_buttons", 32'(buttons), 32'h01);
      repeat (3) @(negedge clk);

      // Reset in the middle of a read, during a clock-high phase.
      pressed = 8'h90;
      no_pad = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      check("pre_reset_clk_high", 32'(nes_clk), 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_latch", 32'(nes_latch), 0);
      check("midrst_clk", 32'(nes_clk), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_valid", 32'(valid), 0);
      check("midrst_buttons", 32'(buttons), 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_read(8'h90, 1'b0, 0, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
`ifdef NES_PAD_DEBOUNCE_EN
      exp_btn = 8'h00;
`else
      exp_btn = 8'h90;
`endif
      check("postrst_valid_cycle", 32'(vcyc), 73);
      check("postrst_rises", 32'(rises), 8);
      check("postrst_buttons", 32'(btn), 32'(exp_btn));

`ifdef NES_PAD_DEBOUNCE_EN
      run_read(8'h01, 1'b0, 0, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
      check("deb1_valid", 32'(vcnt), 1);
      check("deb1_buttons", 32'(btn), 32'h00);
      run_read(8'h03, 1'b0, 0, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
      check("deb2_valid", 32'(vcnt), 1);
      check("deb2_buttons", 32'(btn), 32'h00);
      run_read(8'h03, 1'b0, 0, vcyc, vcnt, rises, lfirst, lcnt, busy_end, btn);
      check("deb3_valid", 32'(vcnt), 1);
      check("deb3_buttons", 32'(btn), 32'h03);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
Serial reader for a standard NES controller. It drives the pad's latch and clock pins and samples the pad's serial data line. It assembles the 8 button bits into a parallel, active-high word once per trigger. It sits directly upstream of the input controller, replaces the tied-off NES_Latch/NES_Clk/NES_Data path at the top level, and is triggered by the sync generator's frame_end pulse.

Parameters:
HALF_PERIOD, 151, clk cycles per half serial period (~6 us at 25.175 MHz); legal minimum 4.
CNT_W, $clog2(2*HALF_PERIOD), width of the phase counter (derived; do not override).

Ports:
clk  in  1  system clock (pixel clock)
rst_n  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a read (frame_end)
nes_data  in  1  pad serial data; asynchronous, active-low buttons, pulled up externally
nes_latch  out  1  pad latch strobe
nes_clk  out  1  pad shift clock
buttons  out  8  registered button state, active-high: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
valid  out  1  one-cycle pulse when a read completes
busy  out  1  high while a read is in progress

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Next cycle: nes_latch=0, nes_clk=0, buttons=8'h00, valid=0, busy=0.
  - FSM returns to IDLE and the phase and bit counters clear.
  - This applies mid-read: any partial word is discarded.
- nes_data passes through a 2-flop synchronizer before use. All sampling uses the synchronized value.
- FSM states and transitions:
  - IDLE: all outputs low except buttons. start=1 moves to LATCH on the next cycle. start is ignored in every other state.
  - LATCH: nes_latch=1 for exactly 2*HALF_PERIOD cycles, then LOW with bit index 0.
  - LOW: nes_clk=0 for HALF_PERIOD cycles. On the last cycle, shift register bit[index] <= ~sync_data, so the first serial bit lands in bit 0. Then go to HIGH.
  - HIGH: nes_clk=1 for HALF_PERIOD cycles. If index==7, go to DONE; otherwise increment index and go to LOW. Exactly 8 clock pulses are issued per read.
  - DONE: lasts one cycle. buttons <= shift register, valid=1, then IDLE.
- busy=1 in LATCH, LOW, HIGH and DONE.
- Timing: start sampled high at edge t gives nes_latch high from cycle t+1. valid is asserted in cycle t+1+18*HALF_PERIOD. A new start is accepted in the cycle after DONE.
- A start coincident with the valid cycle is dropped.
- With no pad connected, data reads as 1 and buttons=8'h00.
- buttons holds its value between reads. valid is never high for more than one cycle.
- Phase counter counts down from its load value to 0. Bit index is 3 bits. Nothing wraps beyond 7.

Optional Feature:
NES_PAD_DEBOUNCE_EN
- Defined: the block keeps the previous completed word. In DONE, buttons updates only if the new word equals the previous word. The previous word always updates. valid still pulses on every completed read. The previous word resets to 8'h00.
- Undefined: buttons updates on every DONE. No extra register is synthesized.

Decomposition:
- Package nes_pad_pkg holds:
  - button index constants BTN_A..BTN_RIGHT (0..7);
  - the FSM state typedef/encoding IDLE, LATCH, LOW, HIGH, DONE;
  - NES_BITS=8.
- One sub-module is natural: sync_2ff (2-flop synchronizer with reset value 1). It is reusable for ui_in buttons.

Test Plan:
All scenarios use HALF_PERIOD=4.
- Basic read: nes_data model shifts 8'b1111_1110 (A pressed, serial bit0 first), start at t → nes_latch high t+1..t+8, 8 nes_clk pulses of 4 cycles each, valid at t+73, buttons=8'h01, busy low at t+74.
- Direction pattern: pad presents Up+Right pressed → buttons=8'h90. No pad (nes_data=1) → buttons=8'h00.
- Start while busy: second start pulse at t+20 → ignored; exactly one valid at t+73 and exactly 8 nes_clk rising edges.
- Reset mid-read: rst_n=0 at t+30 → next cycle nes_latch=nes_clk=busy=valid=0, buttons=8'h00. A fresh start after release completes normally.
- Back-to-back: start asserted the cycle after valid → new latch begins; start coincident with valid → no new read.
- NES_PAD_DEBOUNCE_EN:
  - reads return 8'h01, then 8'h03, then 8'h03 → buttons stays 8'h00, 8'h00, then becomes 8'h03;
  - valid pulses three times.
